spu_event_counter: RTL and testbench

Event-consumer end of the SPU event interface: receives per-cycle event pulses (`e_id`) plus context (`e_info` = {privilege code, ASID}) and stream ID (`s_id`) from the event unit. It counts each event line in its own counter after privilege, ASID and stream filtering. Counters wrap on overflow and raise sticky flags and an optional interrupt. A simple register port lets software configure, read and preload the counters.

---
 rtl/spu_event_counter.sv | 199 +++++++++++++++++++
 tb/tb_spu_event_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_event_counter.sv
// spu_event_counter: per-line event counters with privilege, ASID and stream
// filtering. Counters wrap and set sticky overflow flags, which can drive an
// interrupt. Software configures, reads and preloads everything through a
// one-cycle register port.
module spu_event_counter #(
    parameter int          NUM_LINES  = 4,
    parameter int          CNT_WIDTH  = 32,
    parameter int          ASID_WIDTH = 16,
    parameter logic        SID_MATCH  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_LINES-1:0]  e_id_i,
    input  logic [ASID_WIDTH+1:0] e_info_i,
    input  logic                  s_id_i,
    input  logic                  reg_req_i,
    input  logic                  reg_we_i,
    input  logic [7:0]            reg_addr_i,
    input  logic [31:0]           reg_wdata_i,
    output logic [31:0]           reg_rdata_o,
    output logic                  reg_rvalid_o,
    output logic                  irq_o
);

    localparam logic [5:0] WORD_CTRL  = 6'd0;
    localparam logic [5:0] WORD_ASIDF = 6'd1;
    localparam logic [5:0] WORD_OVF   = 6'd2;
    localparam logic [5:0] WORD_IRQEN = 6'd3;

    // Registered copies of the event inputs; all filtering works on these.
    logic [NUM_LINES-1:0]  e_id_reg;
    logic [ASID_WIDTH+1:0] e_info_reg;
    logic                  s_id_reg;

    // Configuration and status state.
    logic                  en_reg;
    logic [2:0]            priv_en_reg;     // [0]=M, [1]=S, [2]=U
    logic                  asidf_en_reg;
    logic [ASID_WIDTH-1:0] asid_match_reg;
    logic [NUM_LINES-1:0]  ovf_reg;
    logic [NUM_LINES-1:0]  irqen_reg;
    logic [NUM_LINES-1:0]  ovf_set;
    logic [NUM_LINES*CNT_WIDTH-1:0] cnt_flat;

    logic [31:0]           rdata_reg;
    logic                  rvalid_reg;
    logic                  irq_reg;

    // Decoded register access.
    logic [5:0]            word;
    logic                  wr_strobe;
    logic                  clr;
    logic [NUM_LINES-1:0]  ovf_w1c;
    logic [31:0]           rd_mux;

    // Event qualification.
    logic [1:0]            priv;
    logic [ASID_WIDTH-1:0] asid;
    logic                  priv_ok;
    logic                  asid_ok;
    logic                  qual;

    logic                  unused_bits;

    assign word      = reg_addr_i[7:2];
    assign wr_strobe = reg_req_i & reg_we_i;
    assign clr       = wr_strobe & (word == WORD_CTRL) & reg_wdata_i[1];
    assign ovf_w1c   = (wr_strobe && (word == WORD_OVF)) ? reg_wdata_i[NUM_LINES-1:0] : '0;

    assign priv    = e_info_reg[ASID_WIDTH+1:ASID_WIDTH];
    assign asid    = e_info_reg[ASID_WIDTH-1:0];
    assign priv_ok = ((priv == 2'b01) & priv_en_reg[0]) |
                     ((priv == 2'b10) & priv_en_reg[1]) |
                     ((priv == 2'b11) & priv_en_reg[2]);
    assign asid_ok = ~asidf_en_reg | (asid == asid_match_reg);
    assign qual    = en_reg & (s_id_reg == SID_MATCH) & priv_ok & asid_ok;

    assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i};

    // Input stage: sample event pulses and context every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e_id_reg   <= '0;
            e_info_reg <= '0;
            s_id_reg   <= 1'b0;
        end else begin
            e_id_reg   <= e_id_i;
            e_info_reg <= e_info_i;
            s_id_reg   <= s_id_i;
        end
    end

    // Configuration registers; CLR is a pulse and leaves configuration alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_reg         <= 1'b0;
            priv_en_reg    <= 3'b111;
            asidf_en_reg   <= 1'b0;
            asid_match_reg <= '0;
            irqen_reg      <= '0;
        end else if (wr_strobe) begin
            if (word == WORD_CTRL) begin
                en_reg      <= reg_wdata_i[0];
                priv_en_reg <= reg_wdata_i[6:4];
            end
            if (word == WORD_ASIDF) begin
                asidf_en_reg   <= reg_wdata_i[31];
                asid_match_reg <= reg_wdata_i[ASID_WIDTH-1:0];
            end
            if (word == WORD_IRQEN) begin
                irqen_reg <= reg_wdata_i[NUM_LINES-1:0];
            end
        end
    end

    // One counter per event line: CLR beats a software load beats an increment.
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic                 inc;
            logic                 load;

            assign inc  = e_id_reg[gi] & qual;
            assign load = wr_strobe & (word == 6'(4 + gi));
            assign ovf_set[gi] = inc & ~clr & ~load & (&cnt_reg);
            assign cnt_flat[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;

            // Counter update; wraps naturally from all-ones to zero.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg <= '0;
                end else if (clr) begin
                    cnt_reg <= '0;
                end else if (load) begin
                    cnt_reg <= reg_wdata_i[CNT_WIDTH-1:0];
                end else if (inc) begin
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    // Sticky overflow flags: a fresh overflow wins over a same-edge W1C.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_reg <= '0;
        end else if (clr) begin
            ovf_reg <= '0;
        end else begin
            ovf_reg <= (ovf_reg & ~ovf_w1c) | ovf_set;
        end
    end

    // Read mux over the current (pre-update) register values.
    always_comb begin
        rd_mux = '0;
        case (word)
            WORD_CTRL:  rd_mux = {25'd0, priv_en_reg, 3'b000, en_reg};
            WORD_ASIDF: begin
                rd_mux     = 32'(asid_match_reg);
                rd_mux[31] = asidf_en_reg;
            end
            WORD_OVF:   rd_mux = 32'(ovf_reg);
            WORD_IRQEN: rd_mux = 32'(irqen_reg);
            default: begin
                for (int i = 0; i < NUM_LINES; i++) begin
                    if (word == 6'(4 + i)) begin
                        rd_mux = 32'(cnt_flat[i*CNT_WIDTH +: CNT_WIDTH]);
                    end
                end
            end
        endcase
    end

    // Response stage: every access completes one cycle later; writes return 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= reg_req_i;
            rdata_reg  <= (reg_req_i && !reg_we_i) ? rd_mux : '0;
        end
    end

    // Interrupt is a registered view of enabled overflow flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(ovf_reg & irqen_reg);
        end
    end

    assign reg_rdata_o  = rdata_reg;
    assign reg_rvalid_o = rvalid_reg;
    assign irq_o        = irq_reg;

endmodule

// File: tb/tb_spu_event_counter.sv
// Testbench for spu_event_counter: directed register/event sequences with a
// response scoreboard checked by an independent monitor process.
module tb_spu_event_counter;

    localparam int NL = 4;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NL-1:0] e_id = '0;
    logic [AW+1:0] e_info = '0;
    logic          s_id = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [7:0]    addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          irq;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] exp;
    } resp_t;
    resp_t sb[$];

    spu_event_counter #(
        .NUM_LINES(NL), .CNT_WIDTH(32), .ASID_WIDTH(AW), .SID_MATCH(1'b0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .e_id_i(e_id), .e_info_i(e_info), .s_id_i(s_id),
        .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_rdata_o(rdata), .reg_rvalid_o(rvalid), .irq_o(irq)
    );

    always #5 clk = ~clk;

    // Monitor: pop one expected response per completion pulse.
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            resp_t r;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rvalid: got rdata=%08h with no access outstanding", rdata);
            end else begin
                r = sb.pop_front();
                if (rdata !== r.exp) begin
                    fails++;
                    $display("FAIL resp@%02h: got %08h expected %08h", r.a, rdata, r.exp);
                end else begin
                    $display("ok   resp@%02h = %08h", r.a, rdata);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s = %08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for the next edge without waiting.
    task automatic set_rd(input logic [7:0] a, input logic [31:0] exp);
        resp_t r;
        req = 1'b1; we = 1'b0; addr = a; wdata = '0;
        r.a = a; r.exp = exp;
        sb.push_back(r);
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [31:0] d);
        resp_t r;
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        r.a = a; r.exp = 32'h0;
        sb.push_back(r);
    endtask

    task automatic reg_rd(input logic [7:0] a, input logic [31:0] exp);
        set_rd(a, exp);
        tick();
        req = 1'b0;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        set_wr(a, d);
        tick();
        req = 1'b0;
    endtask

    // n cycles of event pulses, then two idle cycles so counts settle.
    task automatic ev(input logic [NL-1:0] ids, input logic [1:0] pv,
                      input logic [AW-1:0] as, input logic sid, input int n);
        for (int k = 0; k < n; k++) begin
            e_id = ids; e_info = {pv, as}; s_id = sid;
            tick();
        end
        e_id = '0; e_info = '0; s_id = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        reg_rd(8'h00, 32'h70);
        reg_rd(8'h10, 32'h0);
        reg_rd(8'h04, 32'h0);
        reg_rd(8'h08, 32'h0);
        reg_rd(8'h0C, 32'h0);
        reg_rd(8'h40, 32'h0);   // unmapped

        // Basic counting with latency probe on CNT_0
        reg_wr(8'h00, 32'h71);
        for (int k = 0; k < 10; k++) begin
            e_id = 4'b0101; e_info = {2'b01, 16'h0}; s_id = 1'b0;
            if (k == 1)      set_rd(8'h10, 32'd0);
            else if (k == 2) set_rd(8'h10, 32'd1);
            else             req = 1'b0;
            tick();
        end
        req = 1'b0; e_id = '0; e_info = '0;
        tick(); tick();
        reg_rd(8'h10, 32'd10);
        reg_rd(8'h14, 32'd0);
        reg_rd(8'h18, 32'd10);
        reg_rd(8'h1C, 32'd0);

        // Privilege / ASID / stream filtering on line 0
        reg_wr(8'h00, 32'h21);
        reg_wr(8'h04, 32'h80000005);
        reg_rd(8'h00, 32'h21);
        reg_rd(8'h04, 32'h80000005);
        ev(4'b0001, 2'b10, 16'd5, 1'b0, 3);   // counted
        ev(4'b0001, 2'b10, 16'd6, 1'b0, 2);   // wrong ASID
        ev(4'b0001, 2'b01, 16'd5, 1'b0, 2);   // M not enabled
        ev(4'b0001, 2'b10, 16'd5, 1'b1, 2);   // wrong stream
        ev(4'b0001, 2'b00, 16'd5, 1'b0, 2);   // invalid priv
        reg_rd(8'h10, 32'd13);

        // Overflow and interrupt timing on line 1
        reg_wr(8'h00, 32'h71);
        reg_wr(8'h04, 32'h0);
        reg_wr(8'h14, 32'hFFFFFFFE);
        reg_wr(8'h0C, 32'h2);
        reg_rd(8'h14, 32'hFFFFFFFE);
        for (int k = 0; k < 3; k++) begin
            e_id = 4'b0010; e_info = {2'b01, 16'h0};
            tick();
            chk($sformatf("irq_pre_%0d", k), {31'd0, irq}, 32'h0);
        end
        e_id = '0; e_info = '0;
        tick();
        chk("irq_rise", {31'd0, irq}, 32'h1);
        reg_rd(8'h14, 32'd1);
        reg_rd(8'h08, 32'h2);
        reg_wr(8'h08, 32'h2);
        chk("irq_hold", {31'd0, irq}, 32'h1);
        tick();
        chk("irq_fall", {31'd0, irq}, 32'h0);
        reg_rd(8'h08, 32'h0);

        // Load beats same-edge increment
        e_id = 4'b1000; e_info = {2'b01, 16'h0};
        tick();
        e_id = '0; e_info = '0;
        reg_wr(8'h1C, 32'd100);
        tick(); tick();
        reg_rd(8'h1C, 32'd100);

        // New overflow beats same-edge W1C
        reg_wr(8'h18, 32'hFFFFFFFF);
        e_id = 4'b0100; e_info = {2'b01, 16'h0};
        tick();
        e_id = '0; e_info = '0;
        reg_wr(8'h08, 32'h4);
        tick();
        reg_rd(8'h08, 32'h4);
        reg_rd(8'h18, 32'h0);

        // CLR beats same-edge increments
        e_id = 4'b1111; e_info = {2'b01, 16'h0};
        tick();
        e_id = '0; e_info = '0;
        reg_wr(8'h00, 32'h73);
        tick(); tick();
        reg_rd(8'h10, 32'h0);
        reg_rd(8'h14, 32'h0);
        reg_rd(8'h18, 32'h0);
        reg_rd(8'h1C, 32'h0);
        reg_rd(8'h08, 32'h0);
        reg_rd(8'h00, 32'h71);
        reg_rd(8'h0C, 32'h2);

        // Reset mid-stream with a read in flight
        ev(4'b0001, 2'b01, 16'h0, 1'b0, 5);
        reg_rd(8'h10, 32'd5);
        e_id = 4'b1111; e_info = {2'b01, 16'h0};
        set_rd(8'h10, 32'd5);
        tick();
        req = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_rvalid", {31'd0, rvalid}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_irq", {31'd0, irq}, 32'h0);
        tick(); tick();
        e_id = '0; e_info = '0;
        rst_n = 1'b1;
        tick();
        reg_rd(8'h00, 32'h70);
        reg_rd(8'h04, 32'h0);
        reg_rd(8'h08, 32'h0);
        reg_rd(8'h0C, 32'h0);
        reg_rd(8'h10, 32'h0);
        reg_rd(8'h1C, 32'h0);

        // Drain the scoreboard with a bounded wait
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
